fp_norm_round: RTL and testbench

- Post-add stage of the floating-point adder datapath. Consumes the raw signed-magnitude mantissa sum and the pre-add exponent from the mantissa adder stage.
- Normalises iteratively: one right shift on carry-out, otherwise one left shift per cycle until the hidden bit is set.
- Rounds to nearest, ties away from zero, using a single guard bit.
- Emits a packed sign/exponent/fraction result with overflow and underflow flags over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_round_inc.sv | 12 +
 rtl/fp_norm_round.sv | 166 ++++++++++++++++
 tb/tb_fp_norm_round.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the floating-point adder post-add stage: default widths,
// state encoding and the bit layout of the raw mantissa sum.
package fp_pkg;

  localparam int EXP_W_DEF  = 4;
  localparam int FRAC_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Mantissa layout is [carry hidden fraction guard], so positions follow FRAC_W.
  function automatic int carry_bit(input int frac_w);
    return frac_w + 2;
  endfunction

  function automatic int hidden_bit(input int frac_w);
    return frac_w + 1;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam int EXP_MAX    = exp_max(EXP_W_DEF);
  localparam int CARRY_BIT  = carry_bit(FRAC_W_DEF);
  localparam int HIDDEN_BIT = hidden_bit(FRAC_W_DEF);
  localparam int GUARD_BIT  = 0;

endpackage

// File: rtl/fp_round_inc.sv
// Combinational incrementer used to apply the round-half-away-from-zero increment.
module fp_round_inc #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, a} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalise and round stage: iterative shift normalisation, single-guard
// rounding to nearest (ties away), overflow/underflow flagging, valid/ready output.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+2:0] in_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_of,
  output logic              out_uf
);

  localparam int MAG_W = FRAC_W + 3;
  localparam int C_BIT = carry_bit(FRAC_W);
  localparam int H_BIT = hidden_bit(FRAC_W);
  localparam logic [EXP_W:0] EXP_LIM = (EXP_W+1)'(exp_max(EXP_W));
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W:0]      exp_q, exp_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic                out_sign_q, out_sign_d;
  logic [EXP_W-1:0]    out_exp_q, out_exp_d;
  logic [FRAC_W-1:0]   out_frac_q, out_frac_d;
  logic                out_of_q, out_of_d;
  logic                out_uf_q, out_uf_d;

  logic [FRAC_W+1:0]   inc_sum, rnd_mant;
  logic                inc_co, rnd_carry;
  logic [EXP_W:0]      rnd_exp;
  logic [FRAC_W-1:0]   rnd_frac;
  logic [MAG_W-1:0]    shl_mag;

  fp_round_inc #(.W(FRAC_W + 2)) u_inc (
    .a   (mag_q[C_BIT:1]),
    .sum (inc_sum),
    .co  (inc_co)
  );

  always_comb begin
    rnd_mant  = mag_q[GUARD_BIT] ? inc_sum : mag_q[C_BIT:1];
    rnd_carry = rnd_mant[FRAC_W+1] | (mag_q[GUARD_BIT] & inc_co);
    rnd_exp   = rnd_carry ? exp_q + EXP_ONE : exp_q;
    // After a rounding carry the mantissa is 10...0, so the fraction comes one bit higher.
    rnd_frac  = rnd_carry ? rnd_mant[FRAC_W:1] : rnd_mant[FRAC_W-1:0];
    shl_mag   = {mag_q[MAG_W-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mag_d      = mag_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_frac_d = out_frac_q;
    out_of_d   = out_of_q;
    out_uf_d   = out_uf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {1'b0, in_exp};
          mag_d  = in_mag;
          if (in_mag == '0) begin
            out_sign_d = 1'b0;
            out_exp_d  = '0;
            out_frac_d = '0;
            out_of_d   = 1'b0;
            out_uf_d   = 1'b0;
            state_d    = DONE;
          end else if (in_mag[C_BIT]) begin
            mag_d   = {1'b0, in_mag[MAG_W-1:1]};
            exp_d   = {1'b0, in_exp} + EXP_ONE;
            state_d = ROUND;
          end else if (in_mag[H_BIT]) begin
            state_d = ROUND;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (mag_q[H_BIT]) begin
          state_d = ROUND;
        end else if (exp_q <= EXP_ONE) begin
          out_sign_d = 1'b0;
          out_exp_d  = '0;
          out_frac_d = '0;
          out_of_d   = 1'b0;
          out_uf_d   = 1'b1;
          state_d    = DONE;
        end else begin
          mag_d   = shl_mag;
          exp_d   = exp_q - EXP_ONE;
          // Look ahead at the shifted hidden bit so each shift costs exactly one cycle.
          state_d = shl_mag[H_BIT] ? ROUND : SHIFT;
        end
      end
      ROUND: begin
        out_sign_d = sign_q;
        out_exp_d  = rnd_exp[EXP_W-1:0];
        out_frac_d = rnd_frac;
        out_of_d   = 1'b0;
        out_uf_d   = 1'b0;
        if (rnd_exp >= EXP_LIM) begin
          out_exp_d  = '1;
          out_frac_d = '0;
          out_of_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_frac_q <= '0;
      out_of_q   <= 1'b0;
      out_uf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_frac_q <= out_frac_d;
      out_of_q   <= out_of_d;
      out_uf_q   <= out_uf_d;
    end
  end

  // Working operand registers are fully rewritten on every accepted beat.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mag_q  <= mag_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign out_of    = out_of_q;
  assign out_uf    = out_uf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed beats with expected results queued
// at drive time and compared when out_valid appears.
module tb_fp_norm_round;
  import fp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sign;
  logic [3:0] in_exp;
  logic [5:0] in_mag;
  logic       out_valid, out_ready, out_sign;
  logic [3:0] out_exp;
  logic [2:0] out_frac;
  logic       out_of, out_uf;

  typedef struct {
    logic       s;
    logic [3:0] e;
    logic [2:0] f;
    logic       of;
    logic       uf;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_norm_round #(.EXP_W(4), .FRAC_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_of    (out_of),
    .out_uf    (out_uf)
  );

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_ready"}, int'(in_ready), 1);
    chk({tag, "_sign"}, int'(out_sign), 0);
    chk({tag, "_exp"}, int'(out_exp), 0);
    chk({tag, "_frac"}, int'(out_frac), 0);
    chk({tag, "_of"}, int'(out_of), 0);
    chk({tag, "_uf"}, int'(out_uf), 0);
  endtask

  // Drive one beat and return once it has been accepted (accept edge = cycle 0).
  task automatic drive(input logic s, input logic [3:0] e, input logic [5:0] m);
    int guard_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mag   = m;
    guard_cnt = 0;
    while (!in_ready && guard_cnt < 50) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall the consumer, then pop and compare.
  task automatic collect(input string tag, input int hold);
    int   k;
    exp_t x;
    logic [8:0] snap;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    x = sb.pop_front();
    if (!out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    // Latency is the edge at which the consumer first samples out_valid high.
    chk({tag, "_lat"}, k + 1, x.lat);
    if (hold > 0) begin
      snap = {out_sign, out_exp, out_frac, out_of, out_uf};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, int'(out_valid), 1);
        chk({tag, "_hold_ready"}, int'(in_ready), 0);
        chk({tag, "_hold_stable"}, int'({out_sign, out_exp, out_frac, out_of, out_uf}), int'(snap));
      end
      out_ready = 1'b1;
    end
    chk({tag, "_sign"}, int'(out_sign), int'(x.s));
    chk({tag, "_exp"}, int'(out_exp), int'(x.e));
    chk({tag, "_frac"}, int'(out_frac), int'(x.f));
    chk({tag, "_of"}, int'(out_of), int'(x.of));
    chk({tag, "_uf"}, int'(out_uf), int'(x.uf));
    @(negedge clk);
    chk({tag, "_valid_clr"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic beat(input string tag, input logic s, input logic [3:0] e, input logic [5:0] m,
                      input logic es, input logic [3:0] ee, input logic [2:0] ef,
                      input logic eof, input logic euf, input int lat, input int hold);
    exp_t x;
    x.s = es; x.e = ee; x.f = ef; x.of = eof; x.uf = euf; x.lat = lat;
    sb.push_back(x);
    out_ready = (hold == 0);
    drive(s, e, m);
    collect(tag, hold);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("reset");

    beat("norm",       1'b0, 4'd5,  6'b010110, 1'b0, 4'd5,  3'b011, 1'b0, 1'b0, 2, 0);
    beat("carry_rnd",  1'b1, 4'd5,  6'b101010, 1'b1, 4'd6,  3'b011, 1'b0, 1'b0, 2, 0);
    beat("shift2_bp",  1'b0, 4'd6,  6'b000101, 1'b0, 4'd4,  3'b010, 1'b0, 1'b0, 4, 3);
    beat("rnd_carry",  1'b0, 4'd3,  6'b011111, 1'b0, 4'd4,  3'b000, 1'b0, 1'b0, 2, 0);
    beat("ovf_carry",  1'b0, 4'd14, 6'b100000, 1'b0, 4'(EXP_MAX), 3'b000, 1'b1, 1'b0, 2, 0);
    beat("ovf_round",  1'b1, 4'd14, 6'b011111, 1'b1, 4'(EXP_MAX), 3'b000, 1'b1, 1'b0, 2, 0);
    beat("uf_direct",  1'b0, 4'd1,  6'b000110, 1'b0, 4'd0,  3'b000, 1'b0, 1'b1, 2, 0);
    beat("uf_shift",   1'b0, 4'd2,  6'b000011, 1'b0, 4'd0,  3'b000, 1'b0, 1'b1, 3, 0);
    beat("zero",       1'b1, 4'd9,  6'b000000, 1'b0, 4'd0,  3'b000, 1'b0, 1'b0, 1, 0);
    beat("shift4",     1'b1, 4'd9,  6'b000001, 1'b1, 4'd5,  3'b000, 1'b0, 1'b0, 6, 0);
    beat("shift1_grd", 1'b0, 4'd7,  6'b001011, 1'b0, 4'd6,  3'b011, 1'b0, 1'b0, 3, 0);
    beat("carry_grd",  1'b0, 4'd2,  6'b1 << CARRY_BIT | 6'b000011, 1'b0, 4'd3, 3'b001, 1'b0, 1'b0, 2, 0);

    // Abort a beat while it is still shifting; it must vanish without a result.
    out_ready = 1'b1;
    drive(1'b1, 4'd9, 6'b000001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("mid_reset");

    beat("post_reset", 1'b1, 4'd5, 6'b1 << HIDDEN_BIT | 6'b000111, 1'b1, 4'd5, 3'b100, 1'b0, 1'b0, 2, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
